// File: rtl/seg_scan_multi.sv
// seg_scan_multi: multiplexed 7-segment display driver.
// Scans DIGITS digits using a clock-enable slot counter. Display data is held in
// shadow registers that reload once per frame. The driver also provides per-digit
// decimal points and enables, leading-zero blanking and 16-level PWM brightness.
module seg_scan_multi #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned SCAN_HZ        = 4000,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned CS_ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  blank_lz,
  input  logic [3:0]            bright,
  output logic [7:0]            seg_data,
  output logic [DIGITS-1:0]     seg_cs,
  output logic                  frame_done
);

  localparam int unsigned SLOT_CYC = CLK_HZ / SCAN_HZ;
  localparam int unsigned SUB      = SLOT_CYC / 16;
  localparam int unsigned SLOT_W   = $clog2(SLOT_CYC);
  localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [7:0]        SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] CS_MASK  = (CS_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  typedef enum logic {ST_LOAD, ST_SCAN} state_t;

  state_t                state;
  logic [SLOT_W-1:0]     slot_cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*DIGITS-1:0]   data_sh;
  logic [DIGITS-1:0]     dp_sh;
  logic [DIGITS-1:0]     en_sh;
  logic                  blz_sh;
  logic [3:0]            bright_held;

  logic                  slot_last;
  logic                  frame_last;
  logic [3:0]            bright_eff;
  logic [3:0]            phase;
  logic [DIGITS-1:0]     lz_vec;
  logic                  zero_run;
  logic [3:0]            nib;
  logic                  cur_dp;
  logic                  cur_en;
  logic                  cur_lz;
  logic [DIGITS-1:0]     cs_onehot;
  logic [6:0]            hex_seg;
  logic                  lit;
  logic [7:0]            seg_next;
  logic [DIGITS-1:0]     cs_next;

  // Decode the slot position, PWM phase, leading-zero mask and current digit's segments.
  always_comb begin
    slot_last  = (slot_cnt == SLOT_W'(SLOT_CYC - 1));
    frame_last = slot_last && (idx == IDX_W'(DIGITS - 1));
    // At the first cycle of a slot, use the live brightness input. This is the
    // same value that gets latched into bright_held on that edge.
    bright_eff = (slot_cnt == '0) ? bright : bright_held;
    phase      = 4'(slot_cnt / SLOT_W'(SUB));

    // Walk from the most significant digit downwards, tracking whether every
    // nibble seen so far is zero.
    zero_run = 1'b1;
    lz_vec   = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      zero_run = zero_run & (data_sh[4*(DIGITS-1-k) +: 4] == 4'h0);
      lz_vec[DIGITS-1-k] = zero_run && blz_sh && (k != DIGITS - 1);
    end

    nib       = 4'h0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_lz    = 1'b0;
    cs_onehot = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib          = data_sh[4*i +: 4];
        cur_dp       = dp_sh[i];
        cur_en       = en_sh[i];
        cur_lz       = lz_vec[i];
        cs_onehot[i] = 1'b1;
      end
    end

    case (nib)
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      default: hex_seg = 7'h71;
    endcase

    lit      = cur_en && (phase <= bright_eff);
    seg_next = lit ? {cur_dp, (cur_lz ? 7'h00 : hex_seg)} : 8'h00;
    cs_next  = lit ? cs_onehot : '0;
  end

  // Scan sequencer: post-reset shadow load, then slot/digit counting with per-frame reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_LOAD;
      slot_cnt    <= '0;
      idx         <= '0;
      data_sh     <= '0;
      dp_sh       <= '0;
      en_sh       <= '0;
      blz_sh      <= 1'b0;
      bright_held <= '0;
      seg_data    <= SEG_MASK;
      seg_cs      <= CS_MASK;
      frame_done  <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          data_sh    <= data;
          dp_sh      <= dp;
          en_sh      <= digit_en;
          blz_sh     <= blank_lz;
          seg_data   <= SEG_MASK;
          seg_cs     <= CS_MASK;
          frame_done <= 1'b0;
          state      <= ST_SCAN;
        end
        default: begin
          seg_data   <= seg_next ^ SEG_MASK;
          seg_cs     <= cs_next ^ CS_MASK;
          frame_done <= frame_last;
          if (slot_cnt == '0) begin
            bright_held <= bright;
          end
          if (slot_last) begin
            slot_cnt <= '0;
            idx      <= frame_last ? '0 : idx + 1'b1;
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
          if (frame_last) begin
            data_sh <= data;
            dp_sh   <= dp;
            en_sh   <= digit_en;
            blz_sh  <= blank_lz;
          end
        end
      endcase
    end
  end

endmodule
